uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver with a small configuration register file. It recovers 8-bit LSB-first frames from the `in` line, using 16× oversampling of `clk`, so one bit lasts 16 clock cycles. It presents each byte on `out` with a one-cycle `valid_out` pulse, and reports parity and framing faults on `error`/`valid_error`. It sits between a board-level serial pin and byte-consuming logic; configuration arrives over a valid/ready write port.

## Interface
- `OVERSAMPLE`, 16: clock cycles per bit.
- `SYNC_STAGES`, 2: synchronizer flops on `in`.
- `clk` in 1: single clock; the 16× baud clock.
- `rst_n` in 1: synchronous, active-high reset; the name is historical and the polarity is fixed.
- `in` in 1: serial line, idle high, asynchronous to `clk`.
- `clkinVGA` in 1: reserved pin. Unused, never used as a clock, no effect on behaviour.
- `c_valid` in 1: config write request.
- `c_addr` in 4: config register address.
- `c_data` in 8: config write data.
- `c_ready` out 1: config write accepted when `c_valid && c_ready` at a `clk` edge.
- `error` out 2: error code; bit0 = parity error, bit1 = framing error.
- `valid_error` out 1: one-cycle pulse qualifying `error`.
- `out` out 8: last received byte.
- `valid_out` out 1: one-cycle pulse, byte good.

## Operation
- Config registers:
  - Address 0x5, bits[1:0] = parity mode: 00 none, 01 odd, 10 even, 11 treated as none.
  - Address 0x6, bit0 = stop bits: 0 means one, 1 means two.
  - Other addresses: the write is accepted and ignored.
  - Reset values: no parity, one stop bit.
- Frame format: start (0), 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits (1).
- `in` passes through `SYNC_STAGES` flops before any use.
- FSM states:
  - IDLE: a synchronized falling edge starts the counter and moves to START.
  - START: at count 7 (mid-bit) the line is resampled. If it reads 1, it is a glitch: return to IDLE with no output. If it reads 0, go to DATA.
  - DATA: 8 samples, one every 16 cycles, shifted in LSB first. Then go to PARITY if enabled, else STOP.
  - PARITY: one sample; the check is odd or even over the 8 data bits plus the parity bit.
  - STOP: one or two samples; any 0 sampled is a framing error.
  - After STOP, go to IDLE. If the line is still low, wait in IDLE for a 1 before arming edge detection again.
- At the end of a frame:
  - `out` is loaded with the data byte whether or not an error occurred.
  - No error: pulse `valid_out`.
  - Any error: pulse `valid_error` with `error` set. Both bits may be set together. `valid_out` stays 0.
- `error` holds its value until the next `valid_error`.
- `c_ready` = 1 only in IDLE (and 0 during reset), so configuration changes never affect a frame in flight. A write that arrives during a frame stalls until IDLE.

## Timing
- Reset values: `out`=0, `valid_out`=0, `error`=0, `valid_error`=0, `c_ready`=0; FSM in IDLE.
- `c_ready` rises on the first cycle after reset deasserts.
- Reset asserted mid-frame aborts the frame and produces no output pulse.
- Sample k (0 = start bit) is taken 7+16k cycles after the synchronized falling edge.
- `valid_out`/`valid_error` assert 1 cycle after the last stop-bit sample.
  - From the raw line edge, the total is 2 + 7 + 16·(9 + P + S − 1) + 1 cycles, where P = parity enabled (0/1) and S = stop bits (1/2).
  - Tolerance is ±1 cycle for edge asynchrony.
- Frames may be back-to-back: a new start edge may occur right after the stop bit(s).
- Config write: the register updates on the accepting edge and takes effect from the next start bit.

## Structure
- Shared package `uart_pkg` holds:
  - Address constants `ADDR_PARITY`=4'h5 and `ADDR_STOP`=4'h6.
  - Parity mode encodings.
  - Error bit indices.
  - The FSM state enum.
- One sub-module, `uart_rx_sync`: a `SYNC_STAGES` flop synchronizer with a falling-edge detect output.
- The FSM, bit counter, shift register and config registers live in the top level.

## Test plan
- Default config; frames on the line with idle 1s before and after, 16 cycles per bit:
  - Data bits 0,1,0,1,1,1,0,1 (LSB first) → `out`=0xBA, `valid_out` pulse, `valid_error`=0.
  - Then 0x55, 0xAA, 0xFF, 0x80, 0x00 → one `valid_out` per frame, values in order.
- Low pulse on `in` of 4 cycles → no output; the next valid frame is still received.
- Stop bit driven 0 on a frame carrying 0xAA → `valid_error` pulse, `error`=2'b10, `out`=0xAA, no `valid_out`.
- Write 0x5 = 2'b10 (even parity), then send 0xBA with parity bit 1 → `valid_out`. Send it again with parity bit 0 → `error`=2'b01.
- Write 0x6 = 1 (two stop bits); second stop bit driven 0 → framing error. Issue a config write mid-frame → `c_ready`=0 until IDLE.
- Assert reset mid-frame → all outputs 0 next edge, no pulse. The next full frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_rx serial receiver: config addresses,
// parity encodings, error bit positions and the receiver FSM states.
package uart_pkg;

    localparam logic [3:0] ADDR_PARITY = 4'h5;
    localparam logic [3:0] ADDR_STOP   = 4'h6;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_ODD      = 2'b01,
        PAR_EVEN     = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_mode_e;

    localparam int ERR_PARITY = 0;
    localparam int ERR_FRAME  = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    function automatic logic parityEnabled(input parity_mode_e mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line, with a
// one-cycle falling-edge strobe on the synchronized output.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rx_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] stages_q;
    logic                   prev_q;

    // Flops reset to the idle-high line level so reset never looks like a start edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stages_q <= '1;
            prev_q   <= 1'b1;
        end else begin
            stages_q <= {stages_q[SYNC_STAGES-2:0], rx_i};
            prev_q   <= stages_q[SYNC_STAGES-1];
        end
    end

    assign rx_o   = stages_q[SYNC_STAGES-1];
    assign fall_o = prev_q & ~stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled 8N1/8E1/8O1 (one or two stop bits) serial receiver
// with a small valid/ready configuration write port.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    input  logic       clkinVGA,
    input  logic       c_valid,
    input  logic [3:0] c_addr,
    input  logic [7:0] c_data,
    output logic       c_ready,
    output logic [1:0] error,
    output logic       valid_error,
    output logic [7:0] out,
    output logic       valid_out
);

    localparam int                CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] MID   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(OVERSAMPLE - 1);

    logic rxSync;
    logic rxFall;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk),
        .rst_i (rst_n),
        .rx_i  (in),
        .rx_o  (rxSync),
        .fall_o(rxFall)
    );

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       bitIdx_q;
    logic [7:0]       shift_q;
    logic             parErr_q;
    logic             frmErr_q;
    logic             stopIdx_q;
    logic [7:0]       out_q;
    logic             validOut_q;
    logic             validError_q;
    logic [1:0]       error_q;
    logic             cReady_q;
    parity_mode_e     parMode_q;
    logic             twoStop_q;

    logic midBit;
    logic cfgWrite;
    logic parityBad;
    logic stopBad;
    logic unusedInputs;

    assign cnt_d        = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    assign midBit       = (cnt_q == MID);
    assign cfgWrite     = c_valid && cReady_q;
    assign parityBad    = (^{shift_q, rxSync}) ^ (parMode_q == PAR_ODD);
    assign stopBad      = frmErr_q | ~rxSync;
    assign unusedInputs = ^{clkinVGA, c_data[7:2]};

    // c_ready is only raised in IDLE, so config can never change under a frame in flight.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bitIdx_q     <= '0;
            shift_q      <= '0;
            parErr_q     <= 1'b0;
            frmErr_q     <= 1'b0;
            stopIdx_q    <= 1'b0;
            out_q        <= '0;
            validOut_q   <= 1'b0;
            validError_q <= 1'b0;
            error_q      <= '0;
            cReady_q     <= 1'b0;
            parMode_q    <= PAR_NONE;
            twoStop_q    <= 1'b0;
        end else begin
            validOut_q   <= 1'b0;
            validError_q <= 1'b0;
            cnt_q        <= cnt_d;

            if (cfgWrite) begin
                case (c_addr)
                    ADDR_PARITY: parMode_q <= parity_mode_e'(c_data[1:0]);
                    ADDR_STOP:   twoStop_q <= c_data[0];
                    default:     ;
                endcase
            end

            case (state_q)
                S_IDLE: begin
                    cReady_q <= 1'b1;
                    if (rxFall) begin
                        state_q  <= S_START;
                        cnt_q    <= '0;
                        cReady_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (midBit) begin
                        if (rxSync) begin
                            state_q  <= S_IDLE;
                            cReady_q <= 1'b1;
                        end else begin
                            state_q  <= S_DATA;
                            bitIdx_q <= '0;
                            parErr_q <= 1'b0;
                            frmErr_q <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (midBit) begin
                        shift_q <= {rxSync, shift_q[7:1]};
                        if (bitIdx_q == 3'd7) begin
                            state_q   <= parityEnabled(parMode_q) ? S_PARITY : S_STOP;
                            stopIdx_q <= 1'b0;
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (midBit) begin
                        parErr_q <= parityBad;
                        state_q  <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (midBit) begin
                        if (twoStop_q && !stopIdx_q) begin
                            frmErr_q  <= stopBad;
                            stopIdx_q <= 1'b1;
                        end else begin
                            // Byte is published even on error so software can inspect it.
                            out_q    <= shift_q;
                            state_q  <= S_IDLE;
                            cReady_q <= 1'b1;
                            if (parErr_q || stopBad) begin
                                validError_q        <= 1'b1;
                                error_q[ERR_PARITY] <= parErr_q;
                                error_q[ERR_FRAME]  <= stopBad;
                            end else begin
                                validOut_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign c_ready     = cReady_q;
    assign error       = error_q;
    assign valid_error = validError_q;
    assign out         = out_q;
    assign valid_out   = validOut_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: frame reception, glitch rejection,
// parity/framing errors, config stalls and mid-frame reset.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in;
    logic       clkinVGA;
    logic       c_valid;
    logic [3:0] c_addr;
    logic [7:0] c_data;
    logic       c_ready;
    logic [1:0] error;
    logic       valid_error;
    logic [7:0] out;
    logic       valid_out;

    int testCount = 0;
    int failCount = 0;
    int cyc       = 0;
    int startCyc  = 0;
    int outCount  = 0;
    int errCount  = 0;
    int lastLat   = 0;
    int waited    = 0;
    logic [7:0] outLog[$];
    logic [7:0] lastOut    = '0;
    logic [7:0] lastErrOut = '0;
    logic [1:0] lastErr    = '0;
    logic [7:0] burst[5]   = '{8'h55, 8'hAA, 8'hFF, 8'h80, 8'h00};

    uart_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .clkinVGA   (clkinVGA),
        .c_valid    (c_valid),
        .c_addr     (c_addr),
        .c_data     (c_data),
        .c_ready    (c_ready),
        .error      (error),
        .valid_error(valid_error),
        .out        (out),
        .valid_out  (valid_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: records every result strobe seen between clock edges.
    always @(negedge clk) begin
        if (valid_out) begin
            outCount++;
            lastOut = out;
            outLog.push_back(out);
            lastLat = cyc - startCyc;
        end
        if (valid_error) begin
            errCount++;
            lastErr    = error;
            lastErrOut = out;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int nPar, input logic parBit,
                                 input int nStop, input logic stop1, input logic stop2);
        startCyc = cyc;
        in = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            in = data[i];
            step(16);
        end
        if (nPar != 0) begin
            in = parBit;
            step(16);
        end
        in = stop1;
        step(16);
        if (nStop == 2) begin
            in = stop2;
            step(16);
        end
        in = 1'b1;
    endtask

    task automatic writeCfg(input logic [3:0] addr, input logic [7:0] data, output int stall);
        c_valid = 1'b1;
        c_addr  = addr;
        c_data  = data;
        stall   = 0;
        while (c_ready !== 1'b1 && stall < 400) begin
            step(1);
            stall++;
        end
        checkOutput("cfgAccept", {31'd0, c_ready}, 32'd1);
        step(1);
        c_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b1;
        in       = 1'b1;
        clkinVGA = 1'b0;
        c_valid  = 1'b0;
        c_addr   = '0;
        c_data   = '0;
        step(3);

        checkOutput("rstOut", {24'd0, out}, 32'h0);
        checkOutput("rstValidOut", {31'd0, valid_out}, 32'h0);
        checkOutput("rstError", {30'd0, error}, 32'h0);
        checkOutput("rstValidError", {31'd0, valid_error}, 32'h0);
        checkOutput("rstCReady", {31'd0, c_ready}, 32'h0);
        rst_n = 1'b0;
        step(1);
        checkOutput("cReadyAfterRst", {31'd0, c_ready}, 32'h1);
        step(10);

        applyStimulus(8'hBA, 0, 1'b0, 1, 1'b1, 1'b1);
        step(20);
        checkOutput("frameBaCount", outCount, 32'd1);
        checkOutput("frameBaData", {24'd0, lastOut}, 32'hBA);
        checkOutput("frameBaNoErr", errCount, 32'd0);
        checkOutput("frameBaLatency", {31'd0, lastLat >= 153 && lastLat <= 155}, 32'd1);

        for (int i = 0; i < 5; i++) applyStimulus(burst[i], 0, 1'b0, 1, 1'b1, 1'b1);
        step(20);
        checkOutput("burstCount", outCount, 32'd6);
        for (int i = 0; i < 5; i++) checkOutput($sformatf("burst%0d", i), {24'd0, outLog[i+1]}, {24'd0, burst[i]});

        in = 1'b0;
        step(4);
        in = 1'b1;
        step(40);
        checkOutput("glitchNoOut", outCount, 32'd6);
        checkOutput("glitchNoErr", errCount, 32'd0);
        applyStimulus(8'h3C, 0, 1'b0, 1, 1'b1, 1'b1);
        step(20);
        checkOutput("afterGlitchCount", outCount, 32'd7);
        checkOutput("afterGlitchData", {24'd0, lastOut}, 32'h3C);

        applyStimulus(8'hAA, 0, 1'b0, 1, 1'b0, 1'b1);
        step(20);
        checkOutput("stopErrCount", errCount, 32'd1);
        checkOutput("stopErrCode", {30'd0, lastErr}, 32'h2);
        checkOutput("stopErrData", {24'd0, lastErrOut}, 32'hAA);
        checkOutput("stopErrNoOut", outCount, 32'd7);

        writeCfg(4'h5, 8'h02, waited);
        applyStimulus(8'hBA, 1, 1'b1, 1, 1'b1, 1'b1);
        step(20);
        checkOutput("evenGoodCount", outCount, 32'd8);
        checkOutput("evenGoodData", {24'd0, lastOut}, 32'hBA);
        checkOutput("evenGoodLatency", {31'd0, lastLat >= 169 && lastLat <= 171}, 32'd1);
        applyStimulus(8'hBA, 1, 1'b0, 1, 1'b1, 1'b1);
        step(20);
        checkOutput("evenBadCount", errCount, 32'd2);
        checkOutput("evenBadCode", {30'd0, lastErr}, 32'h1);
        checkOutput("errorHolds", {30'd0, error}, 32'h1);
        checkOutput("evenBadNoOut", outCount, 32'd8);

        writeCfg(4'h5, 8'h00, waited);
        writeCfg(4'h6, 8'h01, waited);
        applyStimulus(8'h5A, 0, 1'b0, 2, 1'b1, 1'b0);
        step(20);
        checkOutput("stop2ErrCount", errCount, 32'd3);
        checkOutput("stop2ErrCode", {30'd0, lastErr}, 32'h2);

        fork
            applyStimulus(8'h5A, 0, 1'b0, 2, 1'b1, 1'b1);
            begin
                step(40);
                checkOutput("cReadyMidFrame", {31'd0, c_ready}, 32'h0);
                writeCfg(4'h6, 8'h00, waited);
                checkOutput("cfgStalled", {31'd0, waited > 50}, 32'd1);
            end
        join
        step(20);
        checkOutput("twoStopCount", outCount, 32'd9);
        checkOutput("twoStopData", {24'd0, lastOut}, 32'h5A);
        checkOutput("twoStopLatency", {31'd0, lastLat >= 169 && lastLat <= 171}, 32'd1);

        in = 1'b0;
        step(16);
        in = 1'b1;
        step(8);
        in = 1'b0;
        step(20);
        rst_n = 1'b1;
        in    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midRstOut", {24'd0, out}, 32'h0);
        checkOutput("midRstValidOut", {31'd0, valid_out}, 32'h0);
        checkOutput("midRstError", {30'd0, error}, 32'h0);
        checkOutput("midRstValidError", {31'd0, valid_error}, 32'h0);
        checkOutput("midRstCReady", {31'd0, c_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        step(40);
        checkOutput("midRstNoPulse", outCount, 32'd9);
        checkOutput("midRstNoErrPulse", errCount, 32'd3);
        applyStimulus(8'hC3, 0, 1'b0, 1, 1'b1, 1'b1);
        step(20);
        checkOutput("postRstCount", outCount, 32'd10);
        checkOutput("postRstData", {24'd0, lastOut}, 32'hC3);
        checkOutput("postRstLatency", {31'd0, lastLat >= 153 && lastLat <= 155}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
